// File: rtl/mt_maint_loopback_pkg.sv
// Shared definitions for the MT maintenance loopback engine: mtMR field
// positions, maintenance operation codes, FSM states and pattern helpers.
package mt_maint_loopback_pkg;

    typedef enum logic [3:0] {
        MOP_NOP   = 4'd0,
        MOP_FIXED = 4'd1,
        MOP_INC   = 4'd2,
        MOP_WALK  = 4'd3
    } mop_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_EDGE,
        ST_SEND,
        ST_DONE
    } state_e;

    localparam int MTMR_MDF_MSB    = 15;
    localparam int MTMR_MDF_LSB    = 7;
    localparam int MTMR_BPICLK_BIT = 6;
    localparam int MTMR_MC_BIT     = 5;
    localparam int MTMR_MOP_MSB    = 4;
    localparam int MTMR_MOP_LSB    = 1;
    localparam int MTMR_MM_BIT     = 0;

    function automatic logic [8:0] mtmrMdf(input logic [15:0] mr);
        return mr[MTMR_MDF_MSB:MTMR_MDF_LSB];
    endfunction

    function automatic logic [3:0] mtmrMop(input logic [15:0] mr);
        return mr[MTMR_MOP_MSB:MTMR_MOP_LSB];
    endfunction

    function automatic logic mtmrMm(input logic [15:0] mr);
        return mr[MTMR_MM_BIT];
    endfunction

    function automatic logic mtmrBpiClk(input logic [15:0] mr);
        return mr[MTMR_BPICLK_BIT];
    endfunction

    function automatic logic isRunnableMop(input logic [3:0] mop);
        return (mop == MOP_FIXED) || (mop == MOP_INC) || (mop == MOP_WALK);
    endfunction

    function automatic logic [8:0] initialPattern(input logic [3:0] mop, input logic [8:0] mdf);
        return (mop == MOP_WALK) ? 9'h001 : mdf;
    endfunction

    // Increment wraps naturally at 9 bits; walking ones rotates bit 8 back to bit 0.
    function automatic logic [8:0] nextPattern(input logic [3:0] mop, input logic [8:0] pattern);
        logic [8:0] result;
        case (mop)
            MOP_INC:  result = pattern + 9'd1;
            MOP_WALK: result = {pattern[7:0], pattern[8]};
            default:  result = pattern;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mt_bpi_edge.sv
// One-flop BPI clock sampler producing a registered one-cycle pulse on each
// rising edge of the free-running BPICLK bit.
module mt_bpi_edge (
    input  logic clk,
    input  logic rst,
    input  logic bpiClk_i,
    output logic rise_o
);

    logic sync_q;
    logic rise_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= bpiClk_i;
            rise_q <= bpiClk_i & ~sync_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/mt_maint_loopback.sv
// Maintenance-mode loopback: synthesizes read frames at the BPI rate from the
// mtMR pattern fields and presents them over a valid/ready handshake.
module mt_maint_loopback
    import mt_maint_loopback_pkg::*;
#(
    parameter logic [15:0] FRAMES = 16'd16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mtMR,
    input  logic        mtmrWRITE,
    input  logic        mtmlREADY,
    output logic        mtmlVALID,
    output logic [8:0]  mtmlDATA,
    output logic        mtmlPAR,
    output logic        mtmlBUSY,
    output logic        mtmlDONE,
    output logic        mtmlOVR
);

    state_e      state_q;
    logic        pending_q;
    logic [3:0]  mop_q;
    logic [8:0]  pattern_q;
    logic [15:0] count_q;
    logic        valid_q;
    logic [8:0]  data_q;
    logic        par_q;
    logic        busy_q;
    logic        done_q;
    logic        ovr_q;

    logic        bpiRise;
    logic        startNow;
    logic        lastFrame;
    logic        patternPar;
    logic        unusedMc;

    mt_bpi_edge uBpiEdge (
        .clk      (clk),
        .rst      (rst),
        .bpiClk_i (mtmrBpiClk(mtMR)),
        .rise_o   (bpiRise)
    );

    // MC is reserved for a future single-step mode.
    assign unusedMc   = mtMR[MTMR_MC_BIT];

    assign startNow   = pending_q && mtmrMm(mtMR) && isRunnableMop(mtmrMop(mtMR));
    assign lastFrame  = (count_q + 16'd1) == FRAMES;
    assign patternPar = ~^pattern_q;

    // A write while busy aborts; the registered pending flag then re-evaluates
    // the freshly written mtMR from IDLE, so a valid write restarts cleanly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            mop_q     <= 4'd0;
            pattern_q <= 9'd0;
            count_q   <= 16'd0;
            valid_q   <= 1'b0;
            data_q    <= 9'd0;
            par_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            pending_q <= mtmrWRITE;
            done_q    <= 1'b0;
            if (mtmrWRITE && busy_q) begin
                state_q <= ST_IDLE;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (startNow) begin
                            mop_q     <= mtmrMop(mtMR);
                            pattern_q <= initialPattern(mtmrMop(mtMR), mtmrMdf(mtMR));
                            count_q   <= 16'd0;
                            ovr_q     <= 1'b0;
                            busy_q    <= 1'b1;
                            state_q   <= ST_WAIT_EDGE;
                        end
                    end
                    ST_WAIT_EDGE: begin
                        if (bpiRise) begin
                            data_q  <= pattern_q;
                            par_q   <= patternPar;
                            valid_q <= 1'b1;
                            state_q <= ST_SEND;
                        end
                    end
                    ST_SEND: begin
                        // An edge coinciding with acceptance is simply lost.
                        if (mtmlREADY) begin
                            valid_q   <= 1'b0;
                            pattern_q <= nextPattern(mop_q, pattern_q);
                            count_q   <= count_q + 16'd1;
                            if (lastFrame) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end else begin
                                state_q <= ST_WAIT_EDGE;
                            end
                        end else if (bpiRise) begin
                            ovr_q <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign mtmlVALID = valid_q;
    assign mtmlDATA  = data_q;
    assign mtmlPAR   = par_q;
    assign mtmlBUSY  = busy_q;
    assign mtmlDONE  = done_q;
    assign mtmlOVR   = ovr_q;

endmodule
